// File: rtl/branch_cmp_pkg.sv
// Shared condition codes and pipeline stage record for the decode-stage branch comparator.
package branch_cmp_pkg;

   localparam int unsigned CMP_OP_W = 3;
   localparam int unsigned PERF_W   = 32;

   localparam logic [CMP_OP_W-1:0] CMP_EQ  = 3'd0;
   localparam logic [CMP_OP_W-1:0] CMP_NE  = 3'd1;
   localparam logic [CMP_OP_W-1:0] CMP_LEZ = 3'd2;
   localparam logic [CMP_OP_W-1:0] CMP_GTZ = 3'd3;
   localparam logic [CMP_OP_W-1:0] CMP_LTZ = 3'd4;
   localparam logic [CMP_OP_W-1:0] CMP_GEZ = 3'd5;
   localparam logic [CMP_OP_W-1:0] CMP_LT  = 3'd6;
   localparam logic [CMP_OP_W-1:0] CMP_LTU = 3'd7;

   typedef struct packed {
      logic                valid;
      logic                taken;
      logic                eq;
      logic [CMP_OP_W-1:0] op;
   } stage_t;

   localparam int unsigned STAGE_W = 3 + CMP_OP_W;

endpackage

// File: rtl/branch_cmp_pipe_core.sv
// Combinational branch-condition evaluator: op, d1, d2 -> taken, eq.
module branch_cmp_core
   import branch_cmp_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [CMP_OP_W-1:0] op,
   input  logic [WIDTH-1:0]    d1,
   input  logic [WIDTH-1:0]    d2,
   output logic                taken_c,
   output logic                eq_c
);

   logic neg;
   logic zero;
   logic lt_s;
   logic lt_u;

   // Zero-compare ops look only at d1; its top bit is the sign.
   always_comb begin
      eq_c    = (d1 == d2);
      neg     = d1[WIDTH-1];
      zero    = (d1 == '0);
      lt_s    = ($signed(d1) < $signed(d2));
      lt_u    = (d1 < d2);
      taken_c = 1'b0;
      case (op)
         CMP_EQ:  taken_c = eq_c;
         CMP_NE:  taken_c = !eq_c;
         CMP_LEZ: taken_c = neg || zero;
         CMP_GTZ: taken_c = !neg && !zero;
         CMP_LTZ: taken_c = neg;
         CMP_GEZ: taken_c = !neg;
         CMP_LT:  taken_c = lt_s;
         CMP_LTU: taken_c = lt_u;
         default: taken_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_cmp_pipe.sv
// Branch comparator with PIPE_STAGES result registers, stall/flush from the hazard unit.
// Optional BRANCH_CMP_PERF_EN adds evaluation/taken/stall counters.
module branch_cmp_pipe
   import branch_cmp_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned PIPE_STAGES = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [CMP_OP_W-1:0] in_op,
   input  logic [WIDTH-1:0]    D1,
   input  logic [WIDTH-1:0]    D2,
   input  logic                stall,
   input  logic                flush,
   output logic                out_valid,
   output logic                out_taken,
   output logic                out_eq,
   output logic [CMP_OP_W-1:0] out_op
`ifdef BRANCH_CMP_PERF_EN
   ,
   output logic [PERF_W-1:0]   perf_evals,
   output logic [PERF_W-1:0]   perf_taken,
   output logic [PERF_W-1:0]   perf_bubbles
`endif
);

   logic   taken_c;
   logic   eq_c;
   stage_t in_rec;

   branch_cmp_core #(.WIDTH(WIDTH)) u_core (
      .op      (in_op),
      .d1      (D1),
      .d2      (D2),
      .taken_c (taken_c),
      .eq_c    (eq_c)
   );

   // Record entering the pipe; flags are zeroed for bubbles.
   always_comb begin
      in_rec.valid = in_valid;
      in_rec.taken = in_valid && taken_c;
      in_rec.eq    = in_valid && eq_c;
      in_rec.op    = in_op;
   end

   generate
      if (PIPE_STAGES == 0) begin : g_comb
         assign out_valid = in_rec.valid;
         assign out_taken = in_rec.taken;
         assign out_eq    = in_rec.eq;
         assign out_op    = in_rec.op;
      end else begin : g_pipe
         stage_t chain [PIPE_STAGES+1];

         assign chain[0] = in_rec;

         for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
            stage_t q;

            // Reset and flush clear the stage; stall holds it.
            always_ff @(posedge clk) begin
               if (reset || flush) begin
                  q <= '0;
               end else if (!stall) begin
                  q <= chain[i];
               end
            end

            assign chain[i+1] = q;
         end

         assign out_valid = chain[PIPE_STAGES].valid;
         assign out_taken = chain[PIPE_STAGES].taken;
         assign out_eq    = chain[PIPE_STAGES].eq;
         assign out_op    = chain[PIPE_STAGES].op;
      end
   endgenerate

`ifdef BRANCH_CMP_PERF_EN
   // Counters wrap naturally; flush does not touch them.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_evals   <= '0;
         perf_taken   <= '0;
         perf_bubbles <= '0;
      end else begin
         if (out_valid && !stall) begin
            perf_evals <= perf_evals + PERF_W'(1);
         end
         if (out_valid && out_taken && !stall) begin
            perf_taken <= perf_taken + PERF_W'(1);
         end
         if (stall) begin
            perf_bubbles <= perf_bubbles + PERF_W'(1);
         end
      end
   end
`endif

endmodule

// File: doc/branch_cmp_pipe.md
Name: branch_cmp_pipe

Overview:
- Parametrised successor to the single-function equality comparator in the decode-stage branch path.
- Evaluates one of eight branch conditions on two WIDTH-bit operands: EQ, NE, LEZ, GTZ, LTZ, GEZ, signed LT, unsigned LT.
- Registers the result through PIPE_STAGES pipeline stages, with stall and flush that match the CPU hazard unit.
- Sits between the D-stage register-file read/forward muxes and the NPC logic.

Parameters:
- WIDTH, 32, operand width in bits; legal range 2..64.
- PIPE_STAGES, 1, result register stages; legal values 0, 1, 2; 0 means a purely combinational path from in_* to out_*.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  a branch op is presented this cycle
- in_op  input  3  condition code (see package)
- D1  input  WIDTH  operand rs (forwarded)
- D2  input  WIDTH  operand rt (forwarded)
- stall  input  1  hold all stages unchanged
- flush  input  1  invalidate all stages
- out_valid  output  1  result valid
- out_taken  output  1  condition true (0 whenever out_valid=0)
- out_eq  output  1  D1==D2 for the op in the last stage (legacy zero)
- out_op  output  3  op code carried with the result

Behaviour:
- Condition evaluation is combinational on the in_* side:
  - EQ: D1==D2. NE: D1!=D2.
  - LEZ, GTZ, LTZ, GEZ: D1 compared with 0 as signed; D2 is ignored.
  - LT: $signed(D1)<$signed(D2). LTU: D1<D2 unsigned.
  - Signedness uses bit WIDTH-1 as the sign bit.
- Each stage holds {valid, taken, eq, op}. A stage's taken and eq are forced to 0 when its valid is 0.
- Latency is exactly PIPE_STAGES cycles from in_valid to out_valid, with no stall.
- stall=1 (flush=0): every stage holds its contents and new input is ignored. The upstream stage must hold in_* steady.
- flush=1: every stage's valid, taken and eq clear on the next edge. Flush has priority over stall. The input presented in the flush cycle is discarded.
- stall and flush with PIPE_STAGES=0: both are ignored. Outputs follow inputs, gated by in_valid.
- reset=1: every stage clears to valid=0, taken=0, eq=0, op=0, so all outputs read 0 on the cycle after the reset edge. Reset mid-stall or mid-flush behaves the same way.
- in_valid=0 still advances the pipe: a bubble moves in.
- Boundary values:
  - D1=most-negative value: LTZ=1, LEZ=1, GEZ=0.
  - D1=0: LEZ=1, GEZ=1, GTZ=0, LTZ=0.
  - D1=D2: LT=0, LTU=0, EQ=1.
  - D1 = all ones, D2=0: LTU=0, LT=1.
- All eight op encodings are legal; there is no illegal-op case.

Optional Feature:
- Macro: BRANCH_CMP_PERF_EN.
- When defined, add three outputs:
  - perf_evals (32): counts out_valid pulses that advanced (out_valid=1 and stall=0).
  - perf_taken (32): the subset of those pulses with out_taken=1.
  - perf_bubbles (32): counts cycles where stall=1.
- Counters wrap modulo 2^32, clear on reset, and are not affected by flush.
- When the macro is not defined, none of these ports or registers exist, and the behaviour is otherwise identical.

Decomposition:
- Package branch_cmp_pkg holds:
  - op localparams CMP_EQ=3'd0, CMP_NE=1, CMP_LEZ=2, CMP_GTZ=3, CMP_LTZ=4, CMP_GEZ=5, CMP_LT=6, CMP_LTU=7;
  - CMP_OP_W=3;
  - the stage-record width constant.
- One sub-module, branch_cmp_core: a purely combinational evaluator (op, D1, D2 -> taken, eq), instanced once.
- Pipeline registers are generated in the top with a generate loop over PIPE_STAGES.

Test Plan:
- PIPE_STAGES=1, reset released, in_valid=1, op=EQ, D1=D2=32'h1234_5678 -> next cycle out_valid=1, out_taken=1, out_eq=1, out_op=0.
- op=LT, D1=32'hFFFF_FFFF, D2=0 -> out_taken=1. Same operands with op=LTU -> out_taken=0. Check at PIPE_STAGES=0, 1 and 2 with latencies 0, 1 and 2.
- PIPE_STAGES=2: issue GTZ with D1=5, then assert stall for 3 cycles -> out_valid holds unchanged for 3 cycles, then the result emerges. Assert stall+flush together -> all valid=0 on the next edge.
- Sweep D1 over {0, 1, 32'h8000_0000, 32'h7FFF_FFFF} for LEZ/GTZ/LTZ/GEZ -> match the signed truth table; NE on D1=D2 -> 0.
- Assert reset while both stages are valid -> out_valid=0 and out_taken=0 on the next cycle; with BRANCH_CMP_PERF_EN, all counters read 0.
- With BRANCH_CMP_PERF_EN: 10 branches, 4 taken, 3 stall cycles -> perf_evals=10, perf_taken=4, perf_bubbles=3. Preload perf_evals near 2^32-1 via a long run (or force) -> wraps to 0.
